// File: rtl/wb_initiator_pkg.sv
// Shared types and helpers for the Wishbone initiator and its timeout counter.
package wb_initiator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STROBE  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_OK            = 2'd0,
    CAUSE_ERR           = 2'd1,
    CAUSE_RTY_EXHAUSTED = 2'd2,
    CAUSE_TIMEOUT       = 2'd3
  } cause_e;

  localparam int unsigned RETRY_W = 32'd2;

  // Bits needed to hold a count of 0..limit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 32'd2) ? 32'd1 : $clog2(limit + 32'd1);
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Saturating cycle counter with clear/enable; expired flags the enabled cycle
// in which the count reaches LIMIT.
module wb_timeout_cnt
  import wb_initiator_pkg::*;
#(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned W     = cnt_width(LIMIT)
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 32'd1);
  localparam logic [W-1:0] MAX  = W'(LIMIT);
  localparam logic [W-1:0] ONE  = W'(32'd1);

  logic [W-1:0] count_r;

  // Count enabled cycles since the last clear, holding at LIMIT.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_r <= '0;
    end else if (clr_i) begin
      count_r <= '0;
    end else if (en_i && (count_r != MAX)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired_o = en_i && (count_r >= LAST);

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding pipelined Wishbone initiator: valid/ready request in,
// one response out, with bus-cycle timeout and bounded retry on rty.
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [3:0]            req_sel_i,
  input  logic [31:0]           req_dat_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic [1:0]            rsp_retries_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i,
  input  logic [31:0]           wb_dat_i
);

  localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(32'd1);

  state_e             state_r;
  state_e             next_state_s;
  cause_e             cause_s;
  logic [RETRY_W-1:0] retry_r;
  logic               sample_s;
  logic               retry_inc_s;
  logic               read_ack_s;
  logic               expired_s;
  logic               tmo_clr_s;
  logic               tmo_en_s;

  assign tmo_clr_s = (next_state_s == ST_STROBE) && (state_r != ST_STROBE);
  assign tmo_en_s  = (state_r == ST_STROBE) || (state_r == ST_WAIT);

  wb_timeout_cnt #(.LIMIT(TIMEOUT)) u_timeout_cnt (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (tmo_clr_s),
    .en_i      (tmo_en_s),
    .expired_o (expired_s)
  );

  // Next-state decode; termination is only looked at once the strobe is accepted.
  always_comb begin
    next_state_s = state_r;
    cause_s      = CAUSE_OK;
    retry_inc_s  = 1'b0;
    read_ack_s   = 1'b0;
    sample_s     = (state_r == ST_WAIT) || ((state_r == ST_STROBE) && !wb_stall_i);
    case (state_r)
      ST_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          next_state_s = ST_STROBE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_STROBE, ST_WAIT: begin
        if (sample_s && wb_err_i) begin
          next_state_s = ST_RESP;
          cause_s      = CAUSE_ERR;
        end else if (sample_s && wb_rty_i) begin
          if (retry_r < MAX_RETRY_C) begin
            next_state_s = ST_BACKOFF;
            retry_inc_s  = 1'b1;
          end else begin
            next_state_s = ST_RESP;
            cause_s      = CAUSE_RTY_EXHAUSTED;
          end
        end else if (sample_s && wb_ack_i) begin
          next_state_s = ST_RESP;
          read_ack_s   = !wb_we_o;
        end else if (expired_s) begin
          // Termination above takes precedence in the expiry cycle.
          next_state_s = ST_RESP;
          cause_s      = CAUSE_TIMEOUT;
        end else if (sample_s) begin
          next_state_s = ST_WAIT;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_BACKOFF: next_state_s = ST_STROBE;
      ST_RESP:    next_state_s = ST_IDLE;
      default:    next_state_s = ST_IDLE;
    endcase
  end

  // State, latched request and all outputs, registered from the next state.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r       <= ST_IDLE;
      retry_r       <= '0;
      req_ready_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_dat_o     <= 32'd0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      rsp_retries_o <= 2'd0;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_we_o       <= 1'b0;
      wb_adr_o      <= '0;
      wb_sel_o      <= 4'd0;
      wb_dat_o      <= 32'd0;
    end else begin
      state_r       <= next_state_s;
      req_ready_o   <= (next_state_s == ST_IDLE);
      wb_cyc_o      <= (next_state_s == ST_STROBE) || (next_state_s == ST_WAIT);
      wb_stb_o      <= (next_state_s == ST_STROBE);
      rsp_valid_o   <= (next_state_s == ST_RESP);
      rsp_err_o     <= (next_state_s == ST_RESP) && (cause_s != CAUSE_OK);
      rsp_timeout_o <= (next_state_s == ST_RESP) && (cause_s == CAUSE_TIMEOUT);
      if ((state_r == ST_IDLE) && (next_state_s == ST_STROBE)) begin
        wb_we_o  <= req_we_i;
        wb_adr_o <= req_addr_i;
        wb_sel_o <= req_sel_i;
        wb_dat_o <= req_dat_i;
        retry_r  <= '0;
      end else if (retry_inc_s) begin
        retry_r <= retry_r + RETRY_ONE;
      end else begin
        retry_r <= retry_r;
      end
      if (next_state_s == ST_RESP) begin
        rsp_retries_o <= retry_r;
      end
      if (read_ack_s) begin
        rsp_dat_o <= wb_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: a scripted Wishbone register-bank slave plus an
// arithmetic reference model of outcome, latency and strobe/cycle counts.
`timescale 1ns/1ps
module tb_wb_initiator;

  localparam int TMO  = 16;
  localparam int MAXR = 3;
  localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2, K_NONE = 3, K_ERRACK = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = 32'd0, req_dat = 32'd0;
  logic [3:0]  req_sel = 4'd0;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_retries;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_o;
  logic [3:0]  wb_sel;
  logic        wb_ack = 1'b0, wb_err = 1'b0, wb_rty = 1'b0, wb_stall = 1'b0;
  logic [31:0] wb_dat_i = 32'd0;

  always #5 clk = ~clk;

  wb_initiator #(.ADDR_WIDTH(32), .TIMEOUT(TMO), .MAX_RETRY(MAXR)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_sel_i(req_sel), .req_dat_i(req_dat),
    .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .rsp_timeout_o(rsp_timeout), .rsp_retries_o(rsp_retries),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_sel_o(wb_sel), .wb_dat_o(wb_dat_o), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
    .wb_rty_i(wb_rty), .wb_stall_i(wb_stall), .wb_dat_i(wb_dat_i)
  );

  int n_cmp = 0, n_bad = 0;
  logic [31:0] bank [16];
  logic [31:0] mem  [16];
  int scr_kind [8];
  int scr_stall = 0, scr_lat = 0;
  bit noise = 0;

  bit got_rsp;
  int rsp_c, stb_cnt, cyc_cnt, cyc_rises;
  logic o_err, o_to, o_post_valid, o_post_ready, o_we;
  logic [1:0] o_ret;
  logic [31:0] o_dat, o_adr, o_wdat;
  logic [3:0] o_sel;

  logic e_err, e_to;
  logic [1:0] e_ret;
  int e_rc, e_stb, e_cyc;
  logic [31:0] e_dat;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic set_script(input int k0, input int k1, input int k2, input int k3, input int st, input int lt);
    scr_kind[0] = k0; scr_kind[1] = k1; scr_kind[2] = k2; scr_kind[3] = k3;
    for (int k = 4; k < 8; k++) scr_kind[k] = K_ACK;
    scr_stall = st; scr_lat = lt;
  endtask

  task automatic idle_bus();
    wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0; wb_stall = 1'b0; wb_dat_i = $urandom;
  endtask

  // Reference: each attempt occupies stall+lat+1 strobe/wait cycles, a retry
  // costs one idle cycle, and the response follows the terminating cycle.
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] dat, input logic [3:0] sel);
    int s, t;
    bit done;
    s = 1; done = 0;
    e_err = 0; e_to = 0; e_ret = 0; e_rc = 0; e_stb = 0; e_cyc = 0; e_dat = 32'd0;
    for (int k = 0; k < 8 && !done; k++) begin
      t = scr_stall + scr_lat + 1;
      if (scr_kind[k] == K_NONE || t > TMO) begin
        e_err = 1; e_to = 1; e_ret = 2'(k); e_rc = s + TMO; e_cyc += TMO;
        e_stb += (scr_kind[k] == K_NONE) ? TMO : ((scr_stall + 1 < TMO) ? scr_stall + 1 : TMO);
        done = 1;
      end else begin
        e_stb += scr_stall + 1;
        e_cyc += t;
        if (scr_kind[k] == K_RTY && k < MAXR) begin
          s = s + t + 1;
        end else begin
          e_rc = s + t; e_ret = 2'(k); e_err = (scr_kind[k] != K_ACK);
          if (!e_err && we) mem[addr[5:2]] = merge(mem[addr[5:2]], dat, sel);
          else if (!e_err) e_dat = mem[addr[5:2]];
          done = 1;
        end
      end
    end
  endtask

  // Issue one request and play the slave script until the response (bounded).
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] dat, input logic [3:0] sel);
    int att, ph, wt, guard;
    bit prev_cyc, term;
    att = 0; ph = 0; wt = 0; guard = 0; prev_cyc = 0;
    got_rsp = 0; rsp_c = 0; stb_cnt = 0; cyc_cnt = 0; cyc_rises = 0;
    o_err = 0; o_to = 0; o_ret = 0; o_dat = 0; o_adr = 0; o_wdat = 0; o_sel = 0; o_we = 0;
    o_post_valid = 0; o_post_ready = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_dat = dat; req_sel = sel;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 200 && !got_rsp; c++) begin
      if (c > 1) @(negedge clk);
      idle_bus();
      term = 0;
      if (wb_cyc) begin cyc_cnt++; if (!prev_cyc) cyc_rises++; end
      prev_cyc = wb_cyc;
      if (wb_cyc && wb_stb) begin
        if (stb_cnt == 0) begin o_adr = wb_adr; o_wdat = wb_dat_o; o_sel = wb_sel; o_we = wb_we; end
        stb_cnt++;
        if (scr_kind[att] == K_NONE || ph < scr_stall) wb_stall = 1'b1;
        else if (scr_lat == 0) term = 1;
        ph++; wt = 0;
      end else if (wb_cyc) begin
        wb_stall = 1'b1; wt++;
        if (wt == scr_lat) term = 1;
      end else begin
        ph = 0;
        if (noise) begin
          wb_ack = 1'($urandom_range(0, 1)); wb_err = 1'($urandom_range(0, 1)); wb_rty = 1'($urandom_range(0, 1));
        end
      end
      if (term) begin
        case (scr_kind[att])
          K_ACK: begin
            wb_ack = 1'b1;
            if (wb_we) bank[wb_adr[5:2]] = merge(bank[wb_adr[5:2]], wb_dat_o, wb_sel);
            else wb_dat_i = bank[wb_adr[5:2]];
          end
          K_ERR:    wb_err = 1'b1;
          K_RTY:    begin wb_rty = 1'b1; if (att < 7) att++; end
          K_ERRACK: begin wb_err = 1'b1; wb_ack = 1'b1; end
          default:  wb_stall = 1'b1;
        endcase
      end
      if (rsp_valid) begin
        got_rsp = 1; rsp_c = c; o_err = rsp_err; o_to = rsp_timeout; o_ret = rsp_retries; o_dat = rsp_dat;
      end
    end
    if (got_rsp) begin
      @(negedge clk);
      idle_bus();
      o_post_valid = rsp_valid; o_post_ready = req_ready;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({wb_cyc, wb_stb, wb_we, rsp_valid, rsp_err, rsp_timeout, req_ready} !== 7'd0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0000000", {wb_cyc, wb_stb, wb_we, rsp_valid, rsp_err, rsp_timeout, req_ready});
    end
    n_cmp++;
    if ({wb_adr, wb_sel, wb_dat_o, rsp_dat, rsp_retries} !== 102'd0) begin
      n_bad++; $display("FAIL reset_data: adr=%h sel=%h dat=%h rdat=%h ret=%0d want all zero", wb_adr, wb_sel, wb_dat_o, rsp_dat, rsp_retries);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_write_read();
    set_script(K_ACK, K_ACK, K_ACK, K_ACK, 0, 0);
    model(1'b1, 32'h0, 32'h12345678, 4'hF);
    do_txn(1'b1, 32'h0, 32'h12345678, 4'hF);
    n_cmp++;
    if (!got_rsp || o_err !== 1'b0 || stb_cnt != 1 || rsp_c != 2) begin
      n_bad++; $display("FAIL write: rsp=%0d err=%b stb=%0d at=%0d want rsp=1 err=0 stb=1 at=2", got_rsp, o_err, stb_cnt, rsp_c);
    end
    n_cmp++;
    if ({o_we, o_adr, o_wdat, o_sel} !== {1'b1, 32'h0, 32'h12345678, 4'hF}) begin
      n_bad++; $display("FAIL write_bus: we=%b adr=%h dat=%h sel=%h want 1/0/12345678/f", o_we, o_adr, o_wdat, o_sel);
    end
    n_cmp++;
    if ({o_post_valid, o_post_ready} !== 2'b01) begin
      n_bad++; $display("FAIL write_spacing: post valid=%b ready=%b want 0 1", o_post_valid, o_post_ready);
    end
    model(1'b0, 32'h0, 32'h0, 4'hF);
    do_txn(1'b0, 32'h0, 32'h0, 4'hF);
    n_cmp++;
    if (!got_rsp || o_err !== 1'b0 || o_dat !== 32'h12345678 || rsp_c != 2) begin
      n_bad++; $display("FAIL readback: rsp=%0d err=%b dat=%h at=%0d want rsp=1 err=0 dat=12345678 at=2", got_rsp, o_err, o_dat, rsp_c);
    end
  endtask

  task automatic test_read_latency();
    bank[3] = 32'hA5C30F1E; mem[3] = 32'hA5C30F1E;
    set_script(K_ACK, K_ACK, K_ACK, K_ACK, 0, 2);
    model(1'b0, 32'hC, 32'h0, 4'hF);
    do_txn(1'b0, 32'hC, 32'h0, 4'hF);
    n_cmp++;
    if (!got_rsp || o_err !== 1'b0 || o_dat !== 32'hA5C30F1E || stb_cnt != 1 || rsp_c != 4) begin
      n_bad++; $display("FAIL read_lat: rsp=%0d err=%b dat=%h stb=%0d at=%0d want 1 0 a5c30f1e 1 4", got_rsp, o_err, o_dat, stb_cnt, rsp_c);
    end
  endtask

  task automatic test_timeout();
    set_script(K_NONE, K_NONE, K_NONE, K_NONE, 0, 0);
    model(1'b0, 32'h4, 32'h0, 4'hF);
    do_txn(1'b0, 32'h4, 32'h0, 4'hF);
    n_cmp++;
    if (!got_rsp || {o_err, o_to, o_ret} !== 4'b1100 || cyc_cnt != 16 || rsp_c != 17) begin
      n_bad++; $display("FAIL timeout: rsp=%0d err=%b to=%b ret=%0d cyc=%0d at=%0d want 1 1 1 0 16 17", got_rsp, o_err, o_to, o_ret, cyc_cnt, rsp_c);
    end
    for (int lt = 15; lt <= 16; lt++) begin
      set_script(K_ACK, K_ACK, K_ACK, K_ACK, 0, lt);
      model(1'b0, 32'h8, 32'h0, 4'hF);
      do_txn(1'b0, 32'h8, 32'h0, 4'hF);
      n_cmp++;
      if (!got_rsp || o_err !== (lt == 16) || o_to !== (lt == 16) || rsp_c != 17) begin
        n_bad++; $display("FAIL timeout_edge lat=%0d: rsp=%0d err=%b to=%b at=%0d want err=to=%0d at=17", lt, got_rsp, o_err, o_to, rsp_c, lt == 16);
      end
    end
  endtask

  task automatic test_retry();
    set_script(K_RTY, K_RTY, K_ACK, K_ACK, 0, 1);
    model(1'b1, 32'h10, 32'hCAFEF00D, 4'h3);
    do_txn(1'b1, 32'h10, 32'hCAFEF00D, 4'h3);
    n_cmp++;
    if (!got_rsp || {o_err, o_to, o_ret} !== 4'b0010 || cyc_rises != 3 || rsp_c != 9) begin
      n_bad++; $display("FAIL retry2: rsp=%0d err=%b to=%b ret=%0d bursts=%0d at=%0d want 1 0 0 2 3 9", got_rsp, o_err, o_to, o_ret, cyc_rises, rsp_c);
    end
    set_script(K_RTY, K_RTY, K_RTY, K_RTY, 0, 1);
    model(1'b0, 32'h10, 32'h0, 4'hF);
    do_txn(1'b0, 32'h10, 32'h0, 4'hF);
    n_cmp++;
    if (!got_rsp || {o_err, o_to, o_ret} !== 4'b1011 || cyc_rises != 4 || rsp_c != 12) begin
      n_bad++; $display("FAIL retry_exhaust: rsp=%0d err=%b to=%b ret=%0d bursts=%0d at=%0d want 1 1 0 3 4 12", got_rsp, o_err, o_to, o_ret, cyc_rises, rsp_c);
    end
  endtask

  task automatic test_err_ack();
    set_script(K_ERRACK, K_ACK, K_ACK, K_ACK, 1, 0);
    model(1'b0, 32'h14, 32'h0, 4'hF);
    do_txn(1'b0, 32'h14, 32'h0, 4'hF);
    n_cmp++;
    if (!got_rsp || {o_err, o_to} !== 2'b10 || rsp_c != 3) begin
      n_bad++; $display("FAIL err_ack: rsp=%0d err=%b to=%b at=%0d want 1 1 0 3", got_rsp, o_err, o_to, rsp_c);
    end
  endtask

  task automatic test_idle_ack();
    int hits;
    hits = 0;
    for (int c = 0; c < 6; c++) begin
      wb_ack = 1'b1; wb_err = c[0]; wb_rty = c[1];
      @(negedge clk);
      if (rsp_valid || wb_cyc) hits++;
    end
    idle_bus();
    @(negedge clk);
    if (rsp_valid || wb_cyc) hits++;
    n_cmp++;
    if (hits != 0) begin n_bad++; $display("FAIL idle_ack: %0d active cycles want 0", hits); end
  endtask

  task automatic test_reset_midwait();
    int hits;
    hits = 0;
    set_script(K_ACK, K_ACK, K_ACK, K_ACK, 0, 10);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4; req_sel = 4'hF;
    @(negedge clk);
    req_valid = 1'b0; idle_bus();
    @(negedge clk);
    wb_stall = 1'b1;
    n_cmp++;
    if ({wb_cyc, wb_stb} !== 2'b10) begin n_bad++; $display("FAIL rst_wait_pre: cyc/stb %b want 10", {wb_cyc, wb_stb}); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({wb_cyc, wb_stb, rsp_valid} !== 3'b000) begin n_bad++; $display("FAIL rst_wait_drop: cyc/stb/rsp %b want 000", {wb_cyc, wb_stb, rsp_valid}); end
    rst_n = 1'b1; idle_bus();
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_wait_ready: got %b want 1", req_ready); end
    for (int c = 0; c < 5; c++) begin
      if (rsp_valid || wb_cyc) hits++;
      @(negedge clk);
    end
    n_cmp++;
    if (hits != 0) begin n_bad++; $display("FAIL rst_wait_quiet: %0d active cycles want 0", hits); end
  endtask

  task automatic test_random();
    int r;
    logic we;
    logic [31:0] addr, dat;
    logic [3:0] sel;
    noise = 1;
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 8; k++) begin
        r = $urandom_range(0, 9);
        scr_kind[k] = (r < 5) ? K_ACK : (r == 5) ? K_ERR : (r < 8) ? K_RTY : (r == 8) ? K_NONE : K_ERRACK;
      end
      scr_stall = $urandom_range(0, 3);
      scr_lat = ($urandom_range(0, 6) == 0) ? $urandom_range(10, 16) : $urandom_range(0, 3);
      we = 1'($urandom_range(0, 1)); addr = $urandom; dat = $urandom; sel = 4'($urandom_range(1, 15));
      model(we, addr, dat, sel);
      do_txn(we, addr, dat, sel);
      n_cmp++;
      if (!got_rsp || {o_err, o_to, o_ret} !== {e_err, e_to, e_ret} || rsp_c != e_rc || stb_cnt != e_stb || cyc_cnt != e_cyc) begin
        n_bad++;
        $display("FAIL random%0d: rsp=%0d err=%b to=%b ret=%0d at=%0d stb=%0d cyc=%0d want 1 %b %b %0d %0d %0d %0d",
                 i, got_rsp, o_err, o_to, o_ret, rsp_c, stb_cnt, cyc_cnt, e_err, e_to, e_ret, e_rc, e_stb, e_cyc);
      end
      if (!we && !e_err) begin
        n_cmp++;
        if (o_dat !== e_dat) begin n_bad++; $display("FAIL random%0d_data: got %h want %h", i, o_dat, e_dat); end
      end
    end
    noise = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin bank[i] = 32'd0; mem[i] = 32'd0; end
    for (int k = 0; k < 8; k++) scr_kind[k] = K_ACK;
    test_reset();
    test_write_read();
    test_read_latency();
    test_timeout();
    test_retry();
    test_err_ack();
    test_idle_ack();
    test_reset_midwait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_initiator.md
# wb_initiator

Single-outstanding Wishbone (pipelined) bus initiator that converts a simple valid/ready request port into bus cycles. It sits between a local controller (sequencer, host bridge, test engine) and generated register banks, i.e. it drives the slave side of those blocks. It adds a bus-cycle timeout and bounded retry on `rty`, and returns exactly one response per accepted request.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of `wb_adr_o` and `req_addr_i`.
- `TIMEOUT`, 255: cycles to wait for termination (`ack`/`err`/`rty`) after `stb` first asserts; range 1..65535.
- `MAX_RETRY`, 3: number of re-issues allowed after `rty`; 0 means `rty` is reported as an error immediately.

Ports:
- Clock and reset: `clk_i` in 1, the single clock. `rst_n_i` in 1, reset; synchronous and active-low.
- Request: `req_valid_i` in 1. `req_ready_o` out 1. `req_we_i` in 1. `req_addr_i` in ADDR_WIDTH. `req_sel_i` in 4. `req_dat_i` in 32.
- Response: `rsp_valid_o` out 1, one-cycle pulse. `rsp_dat_o` out 32, read data. `rsp_err_o` out 1. `rsp_timeout_o` out 1. `rsp_retries_o` out 2, retries consumed.
- Wishbone: `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1. `wb_adr_o` out ADDR_WIDTH. `wb_sel_o` out 4. `wb_dat_o` out 32. `wb_ack_i`, `wb_err_i`, `wb_rty_i`, `wb_stall_i` in 1. `wb_dat_i` in 32.

## Operation
- FSM states: IDLE, STROBE, WAIT, BACKOFF, RESP.
- IDLE: `req_ready_o`=1. On `req_valid_i & req_ready_o`, latch we/addr/sel/dat, clear the retry count, and go to STROBE.
- STROBE: `cyc`=`stb`=1, with address/data/sel/we driven from the latched request.
  - `stall`=0: `stb` drops next cycle and the FSM goes to WAIT.
  - Termination sampled in the same cycle as `stall`=0 is honoured directly; WAIT is skipped.
- WAIT: `cyc`=1, `stb`=0; wait for termination.
- Termination priority: `err` > `rty` > `ack`.
  - `err`: go to RESP with `rsp_err_o`=1.
  - `ack`: go to RESP; on a read, capture `wb_dat_i` into `rsp_dat_o`.
  - `rty` with retries < MAX_RETRY: increment the count and go to BACKOFF.
  - `rty` otherwise: go to RESP with `rsp_err_o`=1.
- BACKOFF: `cyc`=0 for exactly one cycle, then STROBE again with the same latched request.
- Timeout: a counter clears on each entry to STROBE and increments every cycle in STROBE/WAIT. On reaching TIMEOUT with no termination: drop `cyc`/`stb`, go to RESP with `rsp_err_o`=1 and `rsp_timeout_o`=1. Termination in the same cycle the count reaches TIMEOUT wins over timeout.
- RESP: `rsp_valid_o`=1 for one cycle, `cyc`=0, then IDLE. The response port has no backpressure.
- `rsp_dat_o` holds its last value until the next read ack; it is undefined for writes and errors.
- `ack`/`err`/`rty` seen while `cyc`=0 are ignored.

## Timing
- Reset values (every output): `wb_cyc_o`, `wb_stb_o`, `wb_we_o`=0. `wb_adr_o`, `wb_sel_o`, `wb_dat_o`=0. `rsp_valid_o`, `rsp_err_o`, `rsp_timeout_o`=0. `rsp_retries_o`=0. `rsp_dat_o`=0. `req_ready_o`=0 during reset, 1 in the first cycle after reset. FSM in IDLE.
- Reset mid-transfer: bus outputs drop at the reset edge and no response is emitted.
- Request accepted at edge N: `cyc`/`stb` high from N+1.
- Zero-wait slave (ack with `stall`=0 in the first strobe cycle N+1): `rsp_valid_o` at N+2; next request accepted at N+3.
- Minimum spacing: 3 cycles per transfer.
- All outputs are registered. No combinational path from `wb_*_i` to `wb_*_o`.

## Structure
- Package `wb_initiator_pkg`: FSM state enum; termination-cause encoding (OK, ERR, RTY_EXHAUSTED, TIMEOUT); helper function for the counter width from TIMEOUT.
- One sub-module, `wb_timeout_cnt`: a saturating counter with clear/enable and an `expired` output, reusable by other initiators.

## Test plan
- Write: request we=1, addr 0x0, dat 0x12345678, sel 0xF to a register-bank slave. Expect one `stb` cycle, `rsp_valid_o` with err=0, and a subsequent read returning 0x12345678.
- Read against a slave acking 2 cycles after `stb` while holding `stall` until ack. Expect `rsp_dat_o` equal to the slave data, `rsp_valid_o` the cycle after ack, and exactly one `stb` high cycle.
- Slave never terminates (`stall`=1 forever), TIMEOUT=16. Expect `cyc` to drop 16 cycles after `stb` rises, with `rsp_err_o`=1 and `rsp_timeout_o`=1.
- Slave answers `rty` twice then `ack`, MAX_RETRY=3. Expect two 1-cycle `cyc` gaps, then success with `rsp_retries_o`=2. Repeat with 4 `rty`: expect err=1 and retries=3.
- `err` and `ack` asserted together: expect `rsp_err_o`=1. `ack` pulsed while idle: expect no response.
- Reset asserted in WAIT: expect `cyc`=0 next cycle, no `rsp_valid_o`, and `req_ready_o`=1 after reset releases.
